tmr_irq_ctrl: RTL



---
 rtl/tmr_irq_pkg.sv | 13 +
 rtl/tmr_irq_ctrl_if.sv | 26 ++
 rtl/tmr_evt_latch.sv | 70 +++++++
 rtl/tmr_irq_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/tmr_irq_pkg.sv
// Shared constants for the timer interrupt controller: register addresses
// and the bit positions of the overflow/underflow sources.
package tmr_irq_pkg;

  localparam logic [1:0] ADDR_IER    = 2'd0;
  localparam logic [1:0] ADDR_ISR    = 2'd1;
  localparam logic [1:0] ADDR_OVFCNT = 2'd2;
  localparam logic [1:0] ADDR_UDFCNT = 2'd3;

  localparam int BIT_OVF = 0;
  localparam int BIT_UDF = 1;

endpackage

// File: rtl/tmr_irq_ctrl_if.sv
// Flattened APB bus between the CPU fabric and the timer interrupt controller.
interface tmr_irq_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/tmr_evt_latch.sv
// One timer event source: rising-edge detector, sticky pending bit (a new
// event beats a simultaneous W1C) and a saturating event counter (a new
// event beats a simultaneous clear, leaving the counter at 1).
module tmr_evt_latch #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flag_i,
  input  logic                 w1c_i,
  input  logic                 clr_i,
  output logic                 pending_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 prev_q;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic                 rise;

  // Edge history starts at 0, so a flag already high at reset release counts once.
  assign rise = flag_i & ~prev_q;

  // Pending bit: set on a rise, otherwise cleared by W1C, otherwise held.
  always_comb begin
    pend_d = pend_q;
    if (rise) begin
      pend_d = 1'b1;
    end else if (w1c_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Counter: apply a clear first, then increment on a rise unless saturated.
  always_comb begin
    cnt_base = clr_i ? {CNT_WIDTH{1'b0}} : cnt_q;
    cnt_d    = cnt_base;
    if (rise) begin
      if (cnt_base == CNT_MAX) begin
        cnt_d = cnt_base;
      end else begin
        cnt_d = cnt_base + CNT_WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_base;
    end
  end

  // State registers for edge history, pending bit and counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      prev_q <= flag_i;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o = pend_q;
  assign count_o   = cnt_q;

endmodule

// File: rtl/tmr_irq_ctrl.sv
// Timer interrupt controller: APB register file (IER, ISR, two event
// counters), per-source event latches and a registered maskable IRQ line.
module tmr_irq_ctrl
  import tmr_irq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  tmr_irq_ctrl_if.slave        apb,
  input  logic                 TMR_OVF,
  input  logic                 TMR_UDF,
  output logic                 IRQ
);

  logic [1:0]            ier_q, ier_d;
  logic                  irq_q, irq_d;
  logic                  access, addr_ok, wr_en, rd_en;
  logic [1:0]            reg_sel;
  logic [1:0]            w1c;
  logic                  clr_ovf, clr_udf;
  logic [1:0]            isr;
  logic [CNT_WIDTH-1:0]  ovf_cnt, udf_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_wdata;

  // Only the two low address bits decode; anything above 3 is an error.
  assign access  = apb.PSEL & apb.PENABLE;
  assign addr_ok = (apb.PADDR[ADDR_WIDTH-1:2] == {(ADDR_WIDTH-2){1'b0}});
  assign wr_en   = access & apb.PWRITE & addr_ok;
  assign rd_en   = access & ~apb.PWRITE & addr_ok;
  assign reg_sel = apb.PADDR[1:0];

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & ~addr_ok;
  assign apb.PRDATA  = rd_data;

  assign unused_wdata = ^apb.PWDATA[DATA_WIDTH-1:2];

  // Write decode: IER update, ISR W1C strobes and counter clear strobes.
  always_comb begin
    ier_d   = ier_q;
    w1c     = 2'b00;
    clr_ovf = 1'b0;
    clr_udf = 1'b0;
    if (wr_en) begin
      case (reg_sel)
        ADDR_IER:    ier_d   = apb.PWDATA[1:0];
        ADDR_ISR:    w1c     = apb.PWDATA[1:0];
        ADDR_OVFCNT: clr_ovf = 1'b1;
        ADDR_UDFCNT: clr_udf = 1'b1;
        default:     ier_d   = ier_q;
      endcase
    end else begin
      ier_d = ier_q;
    end
  end

  tmr_evt_latch #(.CNT_WIDTH(CNT_WIDTH)) u_ovf (
    .clk_i     (PCLK),
    .rst_ni    (PRESETn),
    .flag_i    (TMR_OVF),
    .w1c_i     (w1c[BIT_OVF]),
    .clr_i     (clr_ovf),
    .pending_o (isr[BIT_OVF]),
    .count_o   (ovf_cnt)
  );

  tmr_evt_latch #(.CNT_WIDTH(CNT_WIDTH)) u_udf (
    .clk_i     (PCLK),
    .rst_ni    (PRESETn),
    .flag_i    (TMR_UDF),
    .w1c_i     (w1c[BIT_UDF]),
    .clr_i     (clr_udf),
    .pending_o (isr[BIT_UDF]),
    .count_o   (udf_cnt)
  );

  assign irq_d = |(isr & ier_q);

  // Read mux: valid reads return the selected register, everything else 0.
  always_comb begin
    rd_data = {DATA_WIDTH{1'b0}};
    if (rd_en) begin
      case (reg_sel)
        ADDR_IER:    rd_data = DATA_WIDTH'(ier_q);
        ADDR_ISR:    rd_data = DATA_WIDTH'(isr);
        ADDR_OVFCNT: rd_data = DATA_WIDTH'(ovf_cnt);
        ADDR_UDFCNT: rd_data = DATA_WIDTH'(udf_cnt);
        default:     rd_data = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rd_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Enable register and registered interrupt output.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ier_q <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      ier_q <= ier_d;
      irq_q <= irq_d;
    end
  end

  assign IRQ = irq_q;

endmodule
